axi4_burst_master: RTL and testbench

Parametrised AXI4 master that turns single commands from a local command port into one AXI4 INCR write or read burst. It supports a configurable data width and ID width, and has a streaming data interface on the local side. It checks for 4 KB boundary crossings, checks response IDs and checks burst length. It sits between local DMA/test logic and the AXI4 interconnect, and has one transaction outstanding at a time.

---
 rtl/axi4_burst_master.sv | 258 +++++++++++++++++++++++++
 tb/tb_axi4_burst_master.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_master.sv
// axi4_burst_master: turns one local command into a single AXI4 INCR burst
// (write or read), with 4 KB boundary, response-ID and burst-length checks.
// One transaction is outstanding at a time.
//
// Handshake semantics: every valid/ready pair transfers exactly on a rising
// edge where both are high; a valid, once raised, is held with stable
// payload until its ready is seen.
module axi4_burst_master #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                  aclk,
    input  logic                  areset,
    // local command port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [ID_W-1:0]       cmd_id,
    // local write-data stream
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_strb,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    // local read-data stream
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_last,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    // completion
    output logic                  done_valid,
    output logic                  done_write,
    output logic [1:0]            done_resp,
    // FSM observation
    output logic [2:0]            fsm_state,
    // AW channel
    output logic [ID_W-1:0]       awid,
    output logic [ADDR_W-1:0]     awaddr,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic                  awlock,
    output logic [3:0]            awcache,
    output logic [2:0]            awprot,
    output logic [3:0]            awqos,
    output logic [0:0]            awuser,
    output logic                  awvalid,
    input  logic                  awready,
    // W channel
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wlast,
    output logic [0:0]            wuser,
    output logic                  wvalid,
    input  logic                  wready,
    // B channel
    input  logic [ID_W-1:0]       bid,
    input  logic [1:0]            bresp,
    input  logic [0:0]            buser,
    input  logic                  bvalid,
    output logic                  bready,
    // AR channel
    output logic [ID_W-1:0]       arid,
    output logic [ADDR_W-1:0]     araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arlock,
    output logic [3:0]            arcache,
    output logic [2:0]            arprot,
    output logic [3:0]            arqos,
    output logic                  arvalid,
    input  logic                  arready,
    // R channel
    input  logic [ID_W-1:0]       rid,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready
);

    localparam int SIZE = $clog2(DATA_W / 8);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_AR   = 3'd4,
        S_R    = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [7:0]        beat_q;
    logic [ID_W-1:0]   id_q;
    logic              write_q;
    logic [1:0]        resp_q;

    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W-1:0] cmd_end;
    logic              crosses;
    logic              w_hs;
    logic              r_hs;
    logic              last_beat;
    logic [1:0]        r_resp_next;
    logic              unused;

    // The start address is aligned to the bus width before any use.
    assign cmd_base  = {cmd_addr[ADDR_W-1:SIZE], {SIZE{1'b0}}};
    assign cmd_end   = cmd_base + ((ADDR_W'(cmd_len) + ADDR_W'(1)) << SIZE) - ADDR_W'(1);
    assign crosses   = cmd_base[ADDR_W-1:12] != cmd_end[ADDR_W-1:12];
    assign last_beat = beat_q == len_q;
    assign w_hs      = (state_q == S_W) && wr_valid && wready;
    assign r_hs      = (state_q == S_R) && rvalid && rd_ready;
    assign unused    = ^{buser, cmd_addr[SIZE-1:0]};

    // Read response accumulation: numeric max, forced to SLVERR on ID or length errors.
    always_comb begin
        r_resp_next = (rresp > resp_q) ? rresp : resp_q;
        if ((rid != id_q) || (rlast != last_beat)) begin
            r_resp_next = 2'b10;
        end
    end

    // State register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (cmd_valid) state_d = crosses ? S_DONE : (cmd_write ? S_AW : S_AR);
            S_AW:   if (awready) state_d = S_W;
            S_W:    if (w_hs && last_beat) state_d = S_B;
            S_B:    if (bvalid) state_d = S_DONE;
            S_AR:   if (arready) state_d = S_R;
            S_R:    if (r_hs && rlast) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Command latch, beat counter and response accumulator.
    always_ff @(posedge aclk) begin
        if (areset) begin
            addr_q  <= '0;
            len_q   <= '0;
            id_q    <= '0;
            write_q <= 1'b0;
            beat_q  <= '0;
            resp_q  <= 2'b00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr_q  <= cmd_base;
                        len_q   <= cmd_len;
                        id_q    <= cmd_id;
                        write_q <= cmd_write;
                        beat_q  <= '0;
                        resp_q  <= crosses ? 2'b10 : 2'b00;
                    end
                end
                S_W: begin
                    if (w_hs) beat_q <= beat_q + 8'd1;
                end
                S_B: begin
                    if (bvalid) resp_q <= (bid != id_q) ? 2'b10 : bresp;
                end
                S_R: begin
                    if (r_hs) begin
                        beat_q <= beat_q + 8'd1;
                        resp_q <= r_resp_next;
                    end
                end
                S_DONE: resp_q <= 2'b00;
                default: ;
            endcase
        end
    end

    // Per-state handshake outputs; data paths pass straight through.
    always_comb begin
        cmd_ready  = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        wr_ready   = 1'b0;
        wlast      = 1'b0;
        bready     = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        rd_valid   = 1'b0;
        rd_last    = 1'b0;
        done_valid = 1'b0;
        case (state_q)
            S_IDLE: cmd_ready = 1'b1;
            S_AW:   awvalid = 1'b1;
            S_W: begin
                wvalid   = wr_valid;
                wr_ready = wready;
                wlast    = last_beat;
            end
            S_B:    bready = 1'b1;
            S_AR:   arvalid = 1'b1;
            S_R: begin
                rready   = rd_ready;
                rd_valid = rvalid;
                rd_last  = rlast;
            end
            S_DONE: done_valid = 1'b1;
            default: ;
        endcase
    end

    assign fsm_state  = state_q;
    assign done_write = write_q;
    assign done_resp  = resp_q;

    assign awid    = id_q;
    assign awaddr  = addr_q;
    assign awlen   = len_q;
    assign awsize  = 3'(SIZE);
    assign awburst = 2'b01;
    assign awlock  = 1'b0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awqos   = 4'd0;
    assign awuser  = 1'b0;

    assign wdata   = wr_data;
    assign wstrb   = wr_strb;
    assign wuser   = 1'b0;

    assign arid    = id_q;
    assign araddr  = addr_q;
    assign arlen   = len_q;
    assign arsize  = 3'(SIZE);
    assign arburst = 2'b01;
    assign arlock  = 1'b0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arqos   = 4'd0;

    assign rd_data = rdata;

endmodule

// File: tb/tb_axi4_burst_master.sv
// Testbench for axi4_burst_master (DATA_W=32): directed commands, a reactive
// AXI slave model, and a negedge monitor that checks every handshake
// against expected queues filled by the stimulus.
module tb_axi4_burst_master;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int ID_W   = 4;

    logic              aclk = 1'b0;
    logic              areset;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [31:0]       cmd_addr;
    logic [7:0]        cmd_len;
    logic [3:0]        cmd_id;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;
    logic              wr_valid, wr_ready;
    logic [31:0]       rd_data;
    logic              rd_last, rd_valid, rd_ready;
    logic              done_valid, done_write;
    logic [1:0]        done_resp;
    logic [2:0]        fsm_state;
    logic [3:0]        awid, arid, bid, rid;
    logic [31:0]       awaddr, araddr, wdata, rdata;
    logic [7:0]        awlen, arlen;
    logic [2:0]        awsize, arsize, awprot, arprot;
    logic [1:0]        awburst, arburst, bresp, rresp;
    logic              awlock, arlock;
    logic [3:0]        awcache, arcache, awqos, arqos, wstrb;
    logic [0:0]        awuser, wuser, buser;
    logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rlast, rvalid, rready;

    // Scoreboard queues.
    logic [49:0] exp_a_q[$];     // {write, addr, len, id, size, burst}
    logic [36:0] exp_w_q[$];     // {wlast, wstrb, wdata}
    logic [32:0] exp_rd_q[$];    // {rd_last, rd_data}
    logic [2:0]  exp_done_q[$];  // {done_write, done_resp}

    int checks = 0;
    int failures = 0;
    int w_count = 0;

    // Monitor-to-slave handshake flags and monitor state.
    logic        aw_hs, ar_hs, w_hs, w_last_hs, b_hs, r_hs;
    logic        w_allowed, aw_hold, ar_hold;
    logic [43:0] aw_prev, ar_prev;

    // Slave model configuration.
    logic        stall_en;
    logic [3:0]  b_id, r_id;
    logic [1:0]  b_resp;
    logic [31:0] r_base;
    int          r_last_at;
    logic [1:0]  r_resp [16];
    logic        b_pend, r_active;
    int          r_idx;

    axi4_burst_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done_valid(done_valid), .done_write(done_write), .done_resp(done_resp),
        .fsm_state(fsm_state),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awqos(awqos), .awuser(awuser),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wuser(wuser), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .buser(buser), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arqos(arqos),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    // Clock.
    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s unexpected handshake actual=1 expected=0", name);
    endtask

    // Monitor: samples on the falling edge, compares handshakes with queues.
    initial begin
        w_allowed = 1'b0; aw_hold = 1'b0; ar_hold = 1'b0;
        aw_prev = '0; ar_prev = '0;
        aw_hs = 0; ar_hs = 0; w_hs = 0; w_last_hs = 0; b_hs = 0; r_hs = 0;
        forever begin
            @(negedge aclk);
            aw_hs     = awvalid && awready;
            ar_hs     = arvalid && arready;
            w_hs      = wvalid && wready;
            w_last_hs = w_hs && wlast;
            b_hs      = bvalid && bready;
            r_hs      = rvalid && rready;
            if (areset) begin
                w_allowed = 1'b0;
                aw_hold   = 1'b0;
                ar_hold   = 1'b0;
            end else begin
                if (aw_hold) check("aw_stable", {awvalid, awaddr, awlen, awid}, {1'b1, aw_prev});
                if (ar_hold) check("ar_stable", {arvalid, araddr, arlen, arid}, {1'b1, ar_prev});
                aw_hold = awvalid && !awready;
                ar_hold = arvalid && !arready;
                aw_prev = {awaddr, awlen, awid};
                ar_prev = {araddr, arlen, arid};
                if (aw_hs) begin
                    if (exp_a_q.size() == 0) unexpected("aw");
                    else check("aw_fields", {1'b1, awaddr, awlen, awid, awsize, awburst}, exp_a_q.pop_front());
                    w_allowed = 1'b1;
                end
                if (ar_hs) begin
                    if (exp_a_q.size() == 0) unexpected("ar");
                    else check("ar_fields", {1'b0, araddr, arlen, arid, arsize, arburst}, exp_a_q.pop_front());
                end
                if (w_hs) begin
                    w_count++;
                    check("w_after_aw", w_allowed, 1);
                    if (exp_w_q.size() == 0) unexpected("w");
                    else check("w_beat", {wlast, wstrb, wdata}, exp_w_q.pop_front());
                    if (wlast) w_allowed = 1'b0;
                end
                if (rd_valid && rd_ready) begin
                    if (exp_rd_q.size() == 0) unexpected("rd");
                    else check("rd_beat", {rd_last, rd_data}, exp_rd_q.pop_front());
                end
                if (done_valid) begin
                    if (exp_done_q.size() == 0) unexpected("done");
                    else check("done", {done_write, done_resp}, exp_done_q.pop_front());
                end
            end
        end
    end

    // Slave model: reacts just after each rising edge to the handshakes seen before it.
    initial begin
        awready = 0; arready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0; buser = 0;
        rvalid = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rd_ready = 0;
        b_pend = 0; r_active = 0; r_idx = 0;
        forever begin
            @(posedge aclk);
            #1;
            if (areset) begin
                b_pend = 0; r_active = 0; bvalid = 0; rvalid = 0; rlast = 0;
            end else begin
                if (b_hs) begin
                    bvalid = 0;
                    b_pend = 0;
                end
                if (w_last_hs) b_pend = 1;
                if (b_pend && !bvalid && (!stall_en || $urandom_range(0, 1) == 1)) begin
                    bvalid = 1; bid = b_id; bresp = b_resp;
                end
                if (r_hs) begin
                    if (rlast) r_active = 0;
                    r_idx++;
                end
                if (ar_hs) begin
                    r_active = 1;
                    r_idx = 0;
                end
                rvalid = r_active;
                rid    = r_id;
                rdata  = r_base + 32'(r_idx);
                rresp  = r_resp[r_idx & 15];
                rlast  = r_active && (r_idx == r_last_at);
            end
            awready  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            arready  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            wready   = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            rd_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Driver tasks (entered just after a rising edge).
    task automatic send_cmd(input logic w, input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
        logic ok;
        cmd_write = w; cmd_addr = addr; cmd_len = len; cmd_id = id; cmd_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge aclk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        if (!ok) unexpected("cmd_ready_timeout");
        @(posedge aclk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic push_w(input int n, input logic [31:0] base, input int len);
        for (int i = 0; i < n; i++) begin
            exp_w_q.push_back({(i == len), 4'hF ^ 4'(i), base + 32'(i)});
        end
    endtask

    task automatic feed_w(input int n, input logic [31:0] base, input int gap);
        logic ok;
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1; wr_data = base + 32'(i); wr_strb = 4'hF ^ 4'(i);
            ok = 1'b0;
            for (int k = 0; k < 200; k++) begin
                @(negedge aclk);
                if (wr_ready) begin ok = 1'b1; break; end
            end
            if (!ok) unexpected("wr_ready_timeout");
            @(posedge aclk);
            #1;
            wr_valid = 1'b0;
            if (i == gap) begin
                repeat (3) @(posedge aclk);
                #1;
            end
        end
    endtask

    task automatic wait_done();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge aclk);
            if (done_valid) begin ok = 1'b1; break; end
        end
        if (!ok) unexpected("done_timeout");
        @(posedge aclk);
        #1;
    endtask

    task automatic set_read(input logic [31:0] base, input logic [3:0] id, input int last_at);
        r_base = base; r_id = id; r_last_at = last_at;
        for (int i = 0; i < 16; i++) r_resp[i] = 2'b00;
    endtask

    // Stimulus.
    initial begin
        int w_start;
        areset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_id = 0;
        wr_data = 0; wr_strb = 0; wr_valid = 0;
        stall_en = 0; b_id = 0; b_resp = 0;
        set_read(32'h0, 4'd0, 0);

        // Reset state.
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("reset_handshakes", {cmd_ready, awvalid, arvalid, wvalid, wr_ready, bready, rready, rd_valid, done_valid},
              9'b1_0000_0000);
        check("reset_state", fsm_state, 3'd0);
        check("reset_aw_fields", {awaddr, awlen, awid}, 44'd0);
        check("reset_ar_fields", {araddr, arlen, arid}, 44'd0);
        check("awsize_const", {awsize, awburst, arsize, arburst}, {3'd2, 2'b01, 3'd2, 2'b01});
        @(posedge aclk);
        #1;
        areset = 0;

        // Write, 4 beats, zero-wait slave.
        b_id = 4'd5; b_resp = 2'b00;
        exp_a_q.push_back({1'b1, 32'h0000_1000, 8'd3, 4'd5, 3'd2, 2'b01});
        push_w(4, 32'h1111_0000, 3);
        exp_done_q.push_back({1'b1, 2'b00});
        w_start = w_count;
        fork
            send_cmd(1'b1, 32'h0000_1000, 8'd3, 4'd5);
            feed_w(4, 32'h1111_0000, -1);
        join
        wait_done();
        check("write1_w_count", w_count - w_start, 4);

        // Read, 8 beats, SLVERR on beat 2.
        set_read(32'hB000_0000, 4'd3, 7);
        r_resp[1] = 2'b01; r_resp[2] = 2'b10;
        exp_a_q.push_back({1'b0, 32'h0000_2000, 8'd7, 4'd3, 3'd2, 2'b01});
        for (int i = 0; i < 8; i++) exp_rd_q.push_back({(i == 7), 32'hB000_0000 + 32'(i)});
        exp_done_q.push_back({1'b0, 2'b10});
        send_cmd(1'b0, 32'h0000_2000, 8'd7, 4'd3);
        wait_done();

        // 4 KB crossing: 0x0FF0 + 32 bytes ends at 0x100F.
        exp_done_q.push_back({1'b1, 2'b10});
        send_cmd(1'b1, 32'h0000_0FF0, 8'd7, 4'd1);
        check("boundary_done_next_cycle", {done_valid, awvalid}, 2'b10);
        @(posedge aclk);
        #1;
        @(negedge aclk);
        check("boundary_cmd_ready_again", cmd_ready, 1);
        @(posedge aclk);
        #1;

        // Backpressure write, unaligned address, gap in wr_valid.
        stall_en = 1; b_id = 4'd2; b_resp = 2'b00;
        exp_a_q.push_back({1'b1, 32'h0000_3040, 8'd5, 4'd2, 3'd2, 2'b01});
        push_w(6, 32'h2222_0000, 5);
        exp_done_q.push_back({1'b1, 2'b00});
        w_start = w_count;
        fork
            send_cmd(1'b1, 32'h0000_3042, 8'd5, 4'd2);
            feed_w(6, 32'h2222_0000, 2);
        join
        wait_done();
        stall_en = 0;
        check("bp_w_count", w_count - w_start, 6);

        // BID mismatch.
        b_id = 4'd6; b_resp = 2'b00;
        exp_a_q.push_back({1'b1, 32'h0000_4000, 8'd0, 4'd5, 3'd2, 2'b01});
        push_w(1, 32'h3333_0000, 0);
        exp_done_q.push_back({1'b1, 2'b10});
        fork
            send_cmd(1'b1, 32'h0000_4000, 8'd0, 4'd5);
            feed_w(1, 32'h3333_0000, -1);
        join
        wait_done();

        // Read len 3 with early rlast on beat 1.
        set_read(32'hC000_0000, 4'd7, 1);
        exp_a_q.push_back({1'b0, 32'h0000_5000, 8'd3, 4'd7, 3'd2, 2'b01});
        exp_rd_q.push_back({1'b0, 32'hC000_0000});
        exp_rd_q.push_back({1'b1, 32'hC000_0001});
        exp_done_q.push_back({1'b0, 2'b10});
        send_cmd(1'b0, 32'h0000_5000, 8'd3, 4'd7);
        wait_done();

        // Reset in W after 2 of 4 beats.
        b_id = 4'd1;
        exp_a_q.push_back({1'b1, 32'h0000_6000, 8'd3, 4'd1, 3'd2, 2'b01});
        push_w(2, 32'h4444_0000, 3);
        fork
            send_cmd(1'b1, 32'h0000_6000, 8'd3, 4'd1);
            feed_w(2, 32'h4444_0000, -1);
        join
        areset = 1;
        @(posedge aclk);
        #1;
        areset = 0;
        wr_valid = 1; wr_data = 32'h4444_0002; wr_strb = 4'hD;
        @(negedge aclk);
        check("reset_mid_w", {wvalid, wr_ready, awvalid, cmd_ready}, 4'b0001);
        @(posedge aclk);
        #1;
        wr_valid = 0;

        // Fresh read ending exactly at a 4 KB boundary (0x7FF8..0x7FFF).
        stall_en = 1;
        set_read(32'hD000_0000, 4'd4, 1);
        r_resp[0] = 2'b01;
        exp_a_q.push_back({1'b0, 32'h0000_7FF8, 8'd1, 4'd4, 3'd2, 2'b01});
        exp_rd_q.push_back({1'b0, 32'hD000_0000});
        exp_rd_q.push_back({1'b1, 32'hD000_0001});
        exp_done_q.push_back({1'b0, 2'b01});
        send_cmd(1'b0, 32'h0000_7FF8, 8'd1, 4'd4);
        wait_done();
        stall_en = 0;

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("exp_a_empty", exp_a_q.size(), 0);
        check("exp_w_empty", exp_w_q.size(), 0);
        check("exp_rd_empty", exp_rd_q.size(), 0);
        check("exp_done_empty", exp_done_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
